prio_encoder_buf: RTL and testbench
===================================

// Module: prio_encoder_buf
// PURPOSE
//  Parametrised N-to-log2(N) priority encoder with request buffering and a registered output.
//  Request pulses are latched into a pending mask. Indices are emitted one per cycle on a valid/ready port.
//  Each emitted index clears its pending bit.
//  Sits between interrupt/event sources and a consumer that services one source per transaction.
// PARAMETERS
//  N      8               number of request lines (>=1; need not be a power of 2)
//  IDX_W  max(1,clog2(N)) localparam; width of out_idx
// PORTS
//  clk        in   1      single clock; all state updates on its rising edge
//  rst        in   1      synchronous, active-high reset
//  req_in     in   N      request pulses; bit i high for a cycle sets pending[i]
//  out_idx    out  IDX_W  encoded index of granted request
//  out_valid  out  1      out_idx holds a granted index
//  out_ready  in   1      consumer accepts out_idx when out_valid&&out_ready
//  pending    out  N      current pending mask (registered)
//  overflow   out  1      1-cycle pulse: a request merged into an already-pending bit
// BEHAVIOUR
//  Reset: pending=0, out_valid=0, out_idx=0, overflow=0, rr pointer=N-1.
//   rst overrides all inputs in the same cycle; a reset mid-stream discards pending and output.
//  load = !out_valid || out_ready.
//   On load with pending!=0: select index s from the registered pending mask.
//   Then out_idx<=s, out_valid<=1, and bit s is cleared.
//   On load with pending==0: out_valid<=0; out_idx keeps its last value.
//  pending_next = (pending & ~clr_mask) | req_in. Set wins: if req_in[s] is high in the grant cycle, bit s stays 1.
//  overflow_next = |(req_in & pending & ~clr_mask), registered, so it appears one cycle later.
//  Latency: req_in at cycle t -> pending at t+1 -> out_valid/out_idx at t+2.
//  Throughput: one index per cycle while out_ready=1 and pending!=0.
//  Backpressure: while out_valid&&!out_ready, out_idx and out_valid hold stable and no new grant occurs.
//   Requests keep accumulating in pending during backpressure.
//  Fixed priority: the highest set index wins (bit N-1 highest). req 8'b1000_0000 -> 7.
//  Indices >= N are never produced. For N=1, out_idx is always 0.
// CONFIGURATION
//  ROUND_ROBIN_EN undefined: fixed highest-index priority; the rr pointer is absent.
//  ROUND_ROBIN_EN defined: a rotating priority pointer ptr (IDX_W bits, reset N-1).
//   The search starts at ptr and descends with wrap (ptr, ptr-1, .., 0, N-1, ..).
//   After a grant of s: ptr <= (s==0) ? N-1 : s-1.
//   The first grant after reset is identical to fixed priority. No starvation.
// STRUCTURE
//  Package prio_enc_pkg:
//   function clog2_min1(int) for IDX_W.
//   Shared localparam RESET_IDX = 0.
//  Sub-module prio_sel (combinational):
//   Inputs: mask[N] and start[IDX_W].
//   Outputs: idx[IDX_W] and any (any bit set).
//   Fixed mode ties start=N-1.
//   Rotation uses double-width mask, priority pick, then modulo N.
//  Top level holds the pending, output, overflow and ptr registers.
// TESTING (N=8, out_ready=1 unless stated)
//  1 reset: rst=1 for 2 cycles with req_in=8'hFF -> after release pending=0, out_valid=0, out_idx=0, overflow=0.
//  2 one-hot sweep: 8'b1000_0000 down to 8'b0000_0001, one pulse per 10 cycles.
//    -> out_idx 7,6,..,0, each valid exactly 1 cycle, 2 cycles after its pulse.
//  3 burst: req_in=8'b1010_0101 for 1 cycle.
//    -> out_idx 7,5,2,0 on consecutive cycles, then out_valid=0 and pending=0.
//  4 backpressure: out_ready=0, req_in=8'h03 pulse.
//    -> out_idx=1 held valid and pending=8'h01. Then raise out_ready -> out_idx=0 next cycle, then idle.
//  5 overflow: with pending[0]=1 and out_ready=0, pulse req_in=8'h01.
//    -> overflow=1 for exactly one cycle and pending unchanged.
//    Same-cycle grant+re-request of bit s -> no overflow and bit s stays set.
//  6 fairness: hold req_in=8'h81 every cycle.
//    -> fixed: out_idx 7,7,7.. with overflow repeatedly high.
//    -> ROUND_ROBIN_EN: 7,0,7,0..
//  Bench also checks: out_idx<N always; out_idx/out_valid stable under backpressure; rst asserted mid-burst clears state next cycle.

Source files
------------

// File: rtl/prio_encoder_buf_pkg.sv
// Shared definitions for the buffered priority encoder.
// Optional feature macro: ROUND_ROBIN_EN (rotating priority pointer).
package prio_enc_pkg;

   // Index width helper: never narrower than one bit, so N=1 still has a port.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Value driven on out_idx after reset.
   localparam int RESET_IDX = 0;

endpackage

// File: rtl/prio_encoder_buf_sel.sv
// Combinational priority pick over a mask.
// The search starts at 'start' and descends with wrap-around.
// Fixed priority is obtained by tying start to N-1.
module prio_sel
   import prio_enc_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = clog2_min1(N)
) (
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [2*N-1:0] dbl;
   int             found;

   assign dbl = {mask, mask};

   // Window dbl[N+start : start+1] is the mask rotated so that bit 'start'
   // sits on top; the highest set bit in it is the winner, folded back mod N.
   always_comb begin
      found = 0;
      for (int j = 0; j < 2*N; j++) begin
         if (j <= N + int'(start) && j > int'(start) && dbl[j])
            found = j;
      end
      idx = (found >= N) ? IDX_W'(found - N) : IDX_W'(found);
      any = |mask;
   end

endmodule

// File: rtl/prio_encoder_buf.sv
// Buffered priority encoder: request pulses accumulate in a pending mask and
// are handed out one index per cycle on a valid/ready port.
// Optional feature macro: ROUND_ROBIN_EN (rotating priority pointer).
module prio_encoder_buf
   import prio_enc_pkg::*;
#(
   parameter int N = 8,
   localparam int IDX_W = clog2_min1(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_in,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     pending,
   output logic             overflow
);

   logic [N-1:0]     pending_q, pending_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             out_valid_q, out_valid_d;
   logic             overflow_q, overflow_d;
   logic [N-1:0]     clr_mask;
   logic [IDX_W-1:0] sel_idx, start;
   logic             sel_any, load, grant;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;
   assign start = ptr_q;
`else
   assign start = IDX_W'(N - 1);
`endif

   prio_sel #(.N(N), .IDX_W(IDX_W)) u_sel (
      .mask  (pending_q),
      .start (start),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   assign load  = !out_valid_q || out_ready;
   assign grant = load && sel_any;

   // Next-state: grant clears the chosen bit, new requests always set (set wins).
   always_comb begin
      clr_mask    = '0;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      if (grant) clr_mask[sel_idx] = 1'b1;
      if (load) out_valid_d = sel_any;
      if (grant) out_idx_d = sel_idx;
      pending_d  = (pending_q & ~clr_mask) | req_in;
      overflow_d = |(req_in & pending_q & ~clr_mask);
`ifdef ROUND_ROBIN_EN
      ptr_d = ptr_q;
      if (grant) ptr_d = (sel_idx == '0) ? IDX_W'(N - 1) : sel_idx - 1'b1;
`endif
   end

   // State registers with synchronous reset overriding all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         out_idx_q   <= IDX_W'(RESET_IDX);
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef ROUND_ROBIN_EN
   // Rotating priority pointer; starts at N-1 so the first grant matches fixed mode.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= IDX_W'(N - 1);
      else     ptr_q <= ptr_d;
   end
`endif

   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_prio_encoder_buf.sv
// Directed bench for prio_encoder_buf (N=8); honours ROUND_ROBIN_EN.
module tb_prio_encoder_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in;
   logic [2:0] out_idx;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] pending;
   logic       overflow;

   int pass_cnt = 0;
   int total    = 0;

   prio_encoder_buf #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pending   (pending),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_in = 8'hFF; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0; req_in = 8'h00;
      total++; if (pending !== 8'h00) $display("FAIL reset_pending got %0h want 0", pending); else pass_cnt++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else pass_cnt++;
      total++; if (out_idx !== 3'd0) $display("FAIL reset_idx got %0d want 0", out_idx); else pass_cnt++;
      total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else pass_cnt++;
   endtask

   task automatic test_onehot();
      for (int k = 7; k >= 0; k--) begin
         req_in = 8'(1 << k);
         tick();
         req_in = 8'h00;
         total++; if (out_valid !== 1'b0) $display("FAIL onehot_early k=%0d got %0b want 0", k, out_valid); else pass_cnt++;
         total++; if (pending !== 8'(1 << k)) $display("FAIL onehot_pend k=%0d got %0h want %0h", k, pending, 8'(1 << k)); else pass_cnt++;
         tick();
         total++; if (out_valid !== 1'b1 || out_idx !== 3'(k)) $display("FAIL onehot_idx got v=%0b i=%0d want v=1 i=%0d", out_valid, out_idx, k); else pass_cnt++;
         tick();
         total++; if (out_valid !== 1'b0) $display("FAIL onehot_len k=%0d got %0b want 0", k, out_valid); else pass_cnt++;
         repeat (7) tick();
      end
   endtask

   task automatic test_burst();
      logic [2:0] exp_idx [4];
      logic [7:0] exp_pend [4];
      exp_idx  = '{3'd7, 3'd5, 3'd2, 3'd0};
      exp_pend = '{8'h25, 8'h05, 8'h01, 8'h00};
      req_in = 8'hA5; tick(); req_in = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (out_valid !== 1'b1 || out_idx !== exp_idx[i]) $display("FAIL burst_idx%0d got v=%0b i=%0d want v=1 i=%0d", i, out_valid, out_idx, exp_idx[i]); else pass_cnt++;
         total++; if (pending !== exp_pend[i]) $display("FAIL burst_pend%0d got %0h want %0h", i, pending, exp_pend[i]); else pass_cnt++;
         total++; if (overflow !== 1'b0) $display("FAIL burst_ovf%0d got %0b want 0", i, overflow); else pass_cnt++;
      end
      tick();
      total++; if (out_valid !== 1'b0 || pending !== 8'h00) $display("FAIL burst_end got v=%0b p=%0h want v=0 p=0", out_valid, pending); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      req_in = 8'h03; tick(); req_in = 8'h00; tick();
      for (int i = 0; i < 3; i++) begin
         total++; if (out_valid !== 1'b1 || out_idx !== 3'd1) $display("FAIL bp_hold%0d got v=%0b i=%0d want v=1 i=1", i, out_valid, out_idx); else pass_cnt++;
         total++; if (pending !== 8'h01) $display("FAIL bp_pend%0d got %0h want 01", i, pending); else pass_cnt++;
         tick();
      end
      out_ready = 1'b1; tick();
      total++; if (out_valid !== 1'b1 || out_idx !== 3'd0) $display("FAIL bp_release got v=%0b i=%0d want v=1 i=0", out_valid, out_idx); else pass_cnt++;
      total++; if (pending !== 8'h00) $display("FAIL bp_release_pend got %0h want 0", pending); else pass_cnt++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL bp_idle got %0b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      req_in = 8'h03; tick(); req_in = 8'h00; tick();
      req_in = 8'h01; tick(); req_in = 8'h00;
      total++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %0b want 1", overflow); else pass_cnt++;
      total++; if (pending !== 8'h01) $display("FAIL ovf_pend got %0h want 01", pending); else pass_cnt++;
      tick();
      total++; if (overflow !== 1'b0) $display("FAIL ovf_len got %0b want 0", overflow); else pass_cnt++;
      total++; if (out_valid !== 1'b1 || out_idx !== 3'd1) $display("FAIL ovf_hold got v=%0b i=%0d want v=1 i=1", out_valid, out_idx); else pass_cnt++;
      out_ready = 1'b1; tick(); tick();
      total++; if (out_valid !== 1'b0 || pending !== 8'h00) $display("FAIL ovf_drain got v=%0b p=%0h want v=0 p=0", out_valid, pending); else pass_cnt++;
      // Re-request of bit 0 in the same cycle it is granted.
      req_in = 8'h01; tick(); tick(); req_in = 8'h00;
      total++; if (out_valid !== 1'b1 || out_idx !== 3'd0) $display("FAIL regrant_idx got v=%0b i=%0d want v=1 i=0", out_valid, out_idx); else pass_cnt++;
      total++; if (pending !== 8'h01) $display("FAIL regrant_pend got %0h want 01", pending); else pass_cnt++;
      total++; if (overflow !== 1'b0) $display("FAIL regrant_ovf got %0b want 0", overflow); else pass_cnt++;
      tick();
      total++; if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending !== 8'h00) $display("FAIL regrant_second got v=%0b i=%0d p=%0h want v=1 i=0 p=0", out_valid, out_idx, pending); else pass_cnt++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL regrant_idle got %0b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      req_in = 8'hFF; tick(); req_in = 8'h00; tick();
      total++; if (out_valid !== 1'b1 || out_idx !== 3'd7) $display("FAIL midrst_pre got v=%0b i=%0d want v=1 i=7", out_valid, out_idx); else pass_cnt++;
      rst = 1'b1; req_in = 8'hFF; tick(); rst = 1'b0; req_in = 8'h00;
      total++; if (pending !== 8'h00 || out_valid !== 1'b0 || out_idx !== 3'd0 || overflow !== 1'b0)
         $display("FAIL midrst_clear got p=%0h v=%0b i=%0d o=%0b want 0 0 0 0", pending, out_valid, out_idx, overflow); else pass_cnt++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_idle got %0b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_fairness();
      logic [2:0] exp;
      rst = 1'b1; tick(); rst = 1'b0;
      req_in = 8'h81; tick();
      for (int i = 0; i < 6; i++) begin
         tick();
`ifdef ROUND_ROBIN_EN
         exp = (i % 2 == 0) ? 3'd7 : 3'd0;
`else
         exp = 3'd7;
`endif
         total++; if (out_valid !== 1'b1 || out_idx !== exp) $display("FAIL fair_idx%0d got v=%0b i=%0d want v=1 i=%0d", i, out_valid, out_idx, exp); else pass_cnt++;
         total++; if (overflow !== 1'b1) $display("FAIL fair_ovf%0d got %0b want 1", i, overflow); else pass_cnt++;
      end
      req_in = 8'h00;
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_in = 8'h00; out_ready = 1'b1;
      test_reset();
      test_onehot();
      test_burst();
      test_backpressure();
      test_overflow();
      test_mid_reset();
      test_fairness();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
